// File: rtl/mem_if_pkg.sv
// Shared definitions for the 512-bit line Memory masters (reader now, writer later).
package mem_if_pkg;

    localparam int LINE_W         = 512;
    localparam int WORD_W         = 32;
    localparam int ADDR_W         = 9;
    localparam int WORDS_PER_LINE = LINE_W / WORD_W;
    localparam int IDX_W          = $clog2(WORDS_PER_LINE);

    // Common transfer sequencing; the writer will walk the same states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_STREAM = 3'd3,
        ST_DONE   = 3'd4
    } line_fsm_t;

endpackage

// File: rtl/line_serializer.sv
// Holds one fetched line and presents it as 16 consecutive 32-bit words,
// lowest word first. The index only moves on an explicit advance, so the
// presented word stays put while the consumer stalls.
module line_serializer
    import mem_if_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    input  logic [LINE_W-1:0] line_in,
    output logic [WORD_W-1:0] word,
    output logic              eol
);

    logic [LINE_W-1:0] r_line;
    logic [IDX_W-1:0]  r_idx;
    logic [WORD_W-1:0] w_words [WORDS_PER_LINE];

    // Line capture and word index; a load always restarts at word 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_line <= '0;
            r_idx  <= '0;
        end else if (load) begin
            r_line <= line_in;
            r_idx  <= '0;
        end else if (advance) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

    // Slice the line into its words so the output is a plain index mux.
    generate
        for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_word
            assign w_words[gi] = r_line[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign word = w_words[r_idx];
    assign eol  = (r_idx == IDX_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/mem_line_reader.sv
// Read master for the line Memory: fetches line_count lines starting at
// base_addr (stepping by ADDR_STRIDE with 9-bit wrap) and streams each line
// out as 16 words on a valid/ready interface. No prefetch: the next line is
// only requested once the last word of the current one is accepted.
module mem_line_reader
    import mem_if_pkg::*;
#(
    parameter int ADDR_STRIDE = 16,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] line_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [LINE_W-1:0] mem_dout,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_eol,
    output logic              word_last
);

    localparam logic [ADDR_W-1:0] STRIDE_V = ADDR_W'(ADDR_STRIDE);
    localparam logic [3:0]        LAT_LAST = 4'(MEM_LAT - 1);

    line_fsm_t         r_state, w_state_next;
    logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_next;
    logic [ADDR_W-1:0] r_lines_left, w_lines_left_next;
    logic [ADDR_W-1:0] r_mem_address, w_mem_address_next;
    logic [3:0]        r_wait_cnt, w_wait_cnt_next;
    logic              w_load;
    logic              w_advance;
    logic              w_eol;
    logic              w_valid;

    // State, address and line counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cur_addr    <= '0;
            r_lines_left  <= '0;
            r_mem_address <= '0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_cur_addr    <= w_cur_addr_next;
            r_lines_left  <= w_lines_left_next;
            r_mem_address <= w_mem_address_next;
            r_wait_cnt    <= w_wait_cnt_next;
        end
    end

    // Next-state, counter updates and state-decoded outputs.
    always_comb begin
        w_state_next       = r_state;
        w_cur_addr_next    = r_cur_addr;
        w_lines_left_next  = r_lines_left;
        w_mem_address_next = r_mem_address;
        w_wait_cnt_next    = r_wait_cnt;
        w_load             = 1'b0;
        w_advance          = 1'b0;
        busy               = (r_state != ST_IDLE);
        done               = (r_state == ST_DONE);
        mem_oe             = (r_state == ST_REQ);
        w_valid            = (r_state == ST_STREAM);

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_cur_addr_next   = base_addr;
                    w_lines_left_next = line_count;
                    if (line_count == '0) begin
                        w_state_next = ST_DONE;
                    end else begin
                        // The address register only moves when heading into
                        // REQ, so it holds its last value everywhere else.
                        w_mem_address_next = base_addr;
                        w_state_next       = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_wait_cnt_next = '0;
                w_state_next    = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == LAT_LAST) begin
                    w_load       = 1'b1;
                    w_state_next = ST_STREAM;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 4'd1;
                end
            end
            ST_STREAM: begin
                if (word_ready) begin
                    if (!w_eol) begin
                        w_advance = 1'b1;
                    end else if (r_lines_left == ADDR_W'(1)) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_cur_addr_next    = r_cur_addr + STRIDE_V;
                        w_mem_address_next = r_cur_addr + STRIDE_V;
                        w_lines_left_next  = r_lines_left - ADDR_W'(1);
                        w_state_next       = ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    line_serializer u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .advance (w_advance),
        .line_in (mem_dout),
        .word    (word_data),
        .eol     (w_eol)
    );

    assign mem_address = r_mem_address;
    assign mem_we      = 1'b0;
    assign word_valid  = w_valid;
    assign word_eol    = w_valid & w_eol;
    assign word_last   = w_valid & w_eol & (r_lines_left == ADDR_W'(1));

endmodule
